// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared types and default widths for the SDRAM request arbiter
//   state_t    : bridge sequencer states
//   port_t     : client port index (PORT_A, PORT_B)
//   ADDR_W_DEF : default byte address width
//   DATA_W_DEF : default data width
package sdram_arb_pkg;

  localparam int ADDR_W_DEF = 27;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_LOW,
    WAIT_HIGH,
    GAP
  } state_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_t;

endpackage

// File: rtl/sdram_arb_sel.sv
// rtl/sdram_arb_sel.sv - combinational winner selector for the two client ports
//   a_req, b_req : pending requests
//   last         : port granted most recently
//   win          : selected port (meaningful only when valid)
//   valid        : at least one request pending
// Macro SDRAM_ARB_RR_EN: defined = round-robin on ties, undefined = port A wins ties.
module sdram_arb_sel
  import sdram_arb_pkg::*;
(
  input  logic  a_req,
  input  logic  b_req,
  input  port_t last,
  output port_t win,
  output logic  valid
);

`ifdef SDRAM_ARB_RR_EN
  always_comb begin
    valid = a_req | b_req;
    win   = PORT_A;
    if (a_req && b_req) begin
      // Tie: the port that was not served last goes first.
      win = (last == PORT_A) ? PORT_B : PORT_A;
    end else if (b_req) begin
      win = PORT_B;
    end
  end
`else
  logic unused_last;
  assign unused_last = last;

  always_comb begin
    valid = a_req | b_req;
    win   = a_req ? PORT_A : (b_req ? PORT_B : PORT_A);
  end
`endif

endmodule

// File: rtl/sdram_arb.sv
// rtl/sdram_arb.sv - two-client arbiter and req/gnt/done bridge to the SDRAM controller strobes
//   clk, reset_n              : clock, asynchronous active-low reset
//   a_*/b_* req,we,addr,wtbt,din : client requests (held until *_gnt)
//   a_*/b_* gnt,done,dout     : grant pulse, completion pulse, read data
//   sd_addr/sd_din/sd_wtbt    : latched request fields to the controller
//   sd_rd/sd_we               : edge-triggered controller strobes
//   sd_dout/sd_ready          : controller read data and ready
//   busy                      : high whenever the sequencer is not idle
// Macro SDRAM_ARB_RR_EN: round-robin tie breaking (default build: fixed priority to port A).
module sdram_arb
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [1:0]        a_wtbt,
  input  logic [DATA_W-1:0] a_din,
  output logic              a_gnt,
  output logic              a_done,
  output logic [DATA_W-1:0] a_dout,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [1:0]        b_wtbt,
  input  logic [DATA_W-1:0] b_din,
  output logic              b_gnt,
  output logic              b_done,
  output logic [DATA_W-1:0] b_dout,
  output logic [ADDR_W-1:0] sd_addr,
  output logic [DATA_W-1:0] sd_din,
  output logic [1:0]        sd_wtbt,
  output logic              sd_rd,
  output logic              sd_we,
  input  logic [DATA_W-1:0] sd_dout,
  input  logic              sd_ready,
  output logic              busy
);

  state_t state, state_nxt;
  port_t  sel_port, last_port, win;
  logic   win_valid, accept, complete;

  sdram_arb_sel u_sel (
    .a_req (a_req),
    .b_req (b_req),
    .last  (last_port),
    .win   (win),
    .valid (win_valid)
  );

`ifdef SDRAM_ARB_RR_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_port <= PORT_B;
    end else if (accept) begin
      last_port <= win;
    end
  end
`else
  assign last_port = PORT_B;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        // Nothing is accepted while the controller is still starting up.
        if (sd_ready && win_valid) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE:     state_nxt = WAIT_LOW;
      WAIT_LOW:  if (!sd_ready) state_nxt = WAIT_HIGH;
      WAIT_HIGH: begin
        if (sd_ready) begin
          complete  = 1'b1;
          state_nxt = GAP;
        end
      end
      GAP:       state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Grant and strobe are registered on the accept edge so both are visible
  // throughout ISSUE; the strobe then stays high until ready returns.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_port <= PORT_A;
      sd_addr  <= '0;
      sd_din   <= '0;
      sd_wtbt  <= '0;
      sd_rd    <= 1'b0;
      sd_we    <= 1'b0;
      a_gnt    <= 1'b0;
      b_gnt    <= 1'b0;
      a_done   <= 1'b0;
      b_done   <= 1'b0;
      a_dout   <= '0;
      b_dout   <= '0;
      busy     <= 1'b0;
    end else begin
      a_gnt  <= 1'b0;
      b_gnt  <= 1'b0;
      a_done <= 1'b0;
      b_done <= 1'b0;
      busy   <= (state_nxt != IDLE);
      if (accept) begin
        sel_port <= win;
        if (win == PORT_B) begin
          sd_addr <= b_addr;
          sd_din  <= b_din;
          sd_wtbt <= b_wtbt;
          sd_we   <= b_we;
          sd_rd   <= ~b_we;
          b_gnt   <= 1'b1;
        end else begin
          sd_addr <= a_addr;
          sd_din  <= a_din;
          sd_wtbt <= a_wtbt;
          sd_we   <= a_we;
          sd_rd   <= ~a_we;
          a_gnt   <= 1'b1;
        end
      end
      if (complete) begin
        // sd_we still holds the direction of the finishing transaction here.
        sd_rd <= 1'b0;
        sd_we <= 1'b0;
        if (sel_port == PORT_B) begin
          b_done <= 1'b1;
          if (!sd_we) b_dout <= sd_dout;
        end else begin
          a_done <= 1'b1;
          if (!sd_we) a_dout <= sd_dout;
        end
      end
    end
  end

endmodule

// File: tb/tb_sdram_arb.sv
// tb/tb_sdram_arb.sv - self-checking bench for sdram_arb with controller model and scoreboard
module tb_sdram_arb;
  import sdram_arb_pkg::*;

`ifdef SDRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        a_req, a_we, b_req, b_we;
  logic [26:0] a_addr, b_addr, sd_addr;
  logic [1:0]  a_wtbt, b_wtbt, sd_wtbt;
  logic [15:0] a_din, b_din, a_dout, b_dout, sd_din, sd_dout;
  logic        a_gnt, a_done, b_gnt, b_done, sd_rd, sd_we, sd_ready, busy;

  sdram_arb dut (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wtbt(a_wtbt), .a_din(a_din),
    .a_gnt(a_gnt), .a_done(a_done), .a_dout(a_dout),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wtbt(b_wtbt), .b_din(b_din),
    .b_gnt(b_gnt), .b_done(b_done), .b_dout(b_dout),
    .sd_addr(sd_addr), .sd_din(sd_din), .sd_wtbt(sd_wtbt), .sd_rd(sd_rd), .sd_we(sd_we),
    .sd_dout(sd_dout), .sd_ready(sd_ready), .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] dflt(input logic [26:0] a);
    return a[15:0] ^ 16'hC3A5;
  endfunction

  // ---------------- controller model ----------------
  logic [15:0] ctl_mem [logic [26:0]];
  logic        ctl_hold, ctl_prev, ctl_is_wr;
  logic [26:0] ctl_addr;
  logic [15:0] ctl_din;
  int          ctl_cnt, ctl_svc_lo, ctl_svc_hi, ctl_edges;

  initial begin
    sd_ready = 1'b1; sd_dout = '0; ctl_prev = 1'b0; ctl_cnt = 0; ctl_edges = 0;
    ctl_is_wr = 1'b0; ctl_addr = '0; ctl_din = '0;
    forever begin
      @(posedge clk); #1;
      if (ctl_hold) begin
        sd_ready = 1'b0;
        ctl_cnt  = 0;
      end else if (ctl_cnt > 0) begin
        ctl_cnt--;
        if (ctl_cnt == 0) begin
          if (ctl_is_wr) ctl_mem[ctl_addr] = ctl_din;
          else sd_dout = ctl_mem.exists(ctl_addr) ? ctl_mem[ctl_addr] : dflt(ctl_addr);
          sd_ready = 1'b1;
        end else begin
          sd_ready = 1'b0;
        end
      end else if ((sd_rd || sd_we) && !ctl_prev) begin
        ctl_edges++;
        ctl_is_wr = sd_we; ctl_addr = sd_addr; ctl_din = sd_din;
        ctl_cnt = 1 + int'($urandom_range(ctl_svc_hi, ctl_svc_lo));
      end else begin
        sd_ready = 1'b1;
      end
      ctl_prev = sd_rd || sd_we;
    end
  end

  // ---------------- scoreboard ----------------
  logic [15:0] ref_mem [logic [26:0]];
  logic        p_a_req, p_b_req, p_a_we, p_b_we, p_ready, p_rd, p_we;
  logic [26:0] p_a_addr, p_b_addr;
  logic [15:0] p_a_din, p_b_din;
  logic [1:0]  p_a_wtbt, p_b_wtbt;
  port_t       m_last, m_port, gp, exp_p;
  logic        m_out, m_we, e_we;
  logic [26:0] m_addr, e_addr;
  logic [15:0] m_din, e_din, exp_a_dout, exp_b_dout, rdata;
  logic [1:0]  e_wtbt;
  int          gnt_total = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_ctrl", 32'({a_gnt, b_gnt, a_done, b_done, sd_rd, sd_we, busy}), 32'd0);
      chk("rst_sd_addr", 32'(sd_addr), 32'd0);
      chk("rst_sd_din_wtbt", 32'({sd_din, sd_wtbt}), 32'd0);
      chk("rst_douts", {a_dout, b_dout}, 32'd0);
      m_last = PORT_B; m_out = 1'b0; exp_a_dout = '0; exp_b_dout = '0;
    end else begin
      chk("one_strobe", 32'(sd_rd && sd_we), 32'd0);
      chk("gnt_onehot", 32'(a_gnt && b_gnt), 32'd0);
      chk("strobe_edge_per_gnt", 32'((sd_rd && !p_rd) || (sd_we && !p_we)), 32'(a_gnt || b_gnt));
      if (a_gnt || b_gnt) begin
        if (p_a_req && p_b_req) exp_p = RR ? ((m_last == PORT_A) ? PORT_B : PORT_A) : PORT_A;
        else exp_p = p_b_req ? PORT_B : PORT_A;
        gp = b_gnt ? PORT_B : PORT_A;
        chk("gnt_port", 32'(gp), 32'(exp_p));
        chk("gnt_had_req", 32'((gp == PORT_B) ? p_b_req : p_a_req), 32'd1);
        chk("gnt_ready_seen", 32'(p_ready), 32'd1);
        chk("gnt_single_txn", 32'(m_out), 32'd0);
        e_we   = (gp == PORT_B) ? p_b_we   : p_a_we;
        e_addr = (gp == PORT_B) ? p_b_addr : p_a_addr;
        e_din  = (gp == PORT_B) ? p_b_din  : p_a_din;
        e_wtbt = (gp == PORT_B) ? p_b_wtbt : p_a_wtbt;
        chk("sd_addr", 32'(sd_addr), 32'(e_addr));
        chk("sd_din", 32'(sd_din), 32'(e_din));
        chk("sd_wtbt", 32'(sd_wtbt), 32'(e_wtbt));
        chk("sd_dir", 32'({sd_rd, sd_we}), 32'({~e_we, e_we}));
        m_out = 1'b1; m_port = gp; m_we = e_we; m_addr = e_addr; m_din = e_din; m_last = gp;
        gnt_total++;
      end
      chk("busy", 32'(busy), 32'(m_out));
      if (a_done || b_done) begin
        chk("done_onehot", 32'(a_done && b_done), 32'd0);
        chk("done_port", 32'(b_done), 32'(m_port == PORT_B));
        chk("done_outstanding", 32'(m_out), 32'd1);
        chk("done_after_ready", 32'(p_ready), 32'd1);
        chk("strobe_fell", 32'({p_rd || p_we, sd_rd || sd_we}), 32'd2);
        if (m_we) begin
          ref_mem[m_addr] = m_din;
        end else begin
          rdata = ref_mem.exists(m_addr) ? ref_mem[m_addr] : dflt(m_addr);
          if (m_port == PORT_B) exp_b_dout = rdata; else exp_a_dout = rdata;
        end
        m_out = 1'b0;
      end
      chk("a_dout", 32'(a_dout), 32'(exp_a_dout));
      chk("b_dout", 32'(b_dout), 32'(exp_b_dout));
    end
    p_a_req = a_req; p_b_req = b_req; p_a_we = a_we; p_b_we = b_we;
    p_a_addr = a_addr; p_b_addr = b_addr; p_a_din = a_din; p_b_din = b_din;
    p_a_wtbt = a_wtbt; p_b_wtbt = b_wtbt; p_ready = sd_ready; p_rd = sd_rd; p_we = sd_we;
  end

  // ---------------- driver helpers ----------------
  typedef struct {
    bit a_new; bit a_w; logic [26:0] a_ad; logic [15:0] a_d; logic [1:0] a_t;
    bit b_new; bit b_w; logic [26:0] b_ad; logic [15:0] b_d; logic [1:0] b_t;
    bit exp_b; bit chk_dout; logic [15:0] exp_dout;
  } vec_t;

  vec_t vecs [9];

  task automatic wait_gnt(output bit got_b, output bit ok);
    ok = 1'b0; got_b = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (a_gnt || b_gnt) begin got_b = b_gnt; ok = 1'b1; break; end
    end
  endtask

  task automatic wait_done(input bit port_b, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (port_b ? b_done : a_done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #1;
      if (a_gnt) a_req = 1'b0;
      if (b_gnt) b_req = 1'b0;
      if (!busy && !a_req && !b_req && !a_gnt && !b_gnt) begin ok = 1'b1; break; end
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  task automatic set_a(input bit w, input logic [26:0] ad, input logic [15:0] d, input logic [1:0] t);
    a_req = 1'b1; a_we = w; a_addr = ad; a_din = d; a_wtbt = t;
  endtask

  task automatic set_b(input bit w, input logic [26:0] ad, input logic [15:0] d, input logic [1:0] t);
    b_req = 1'b1; b_we = w; b_addr = ad; b_din = d; b_wtbt = t;
  endtask

  task automatic run_row(input int idx, input vec_t v);
    bit ok, gb;
    @(posedge clk); #1;
    if (v.a_new) set_a(v.a_w, v.a_ad, v.a_d, v.a_t);
    if (v.b_new) set_b(v.b_w, v.b_ad, v.b_d, v.b_t);
    wait_gnt(gb, ok);
    chk($sformatf("row%0d_gnt_seen", idx), 32'(ok), 32'd1);
    if (ok) begin
      chk($sformatf("row%0d_gnt_port", idx), 32'(gb), 32'(v.exp_b));
      if (gb) b_req = 1'b0; else a_req = 1'b0;
      wait_done(gb, ok);
      chk($sformatf("row%0d_done_seen", idx), 32'(ok), 32'd1);
      if (ok && v.chk_dout)
        chk($sformatf("row%0d_dout", idx), 32'(gb ? b_dout : a_dout), 32'(v.exp_dout));
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit ok, gb;
    int n_gnt, n_strb, lat, e0;
    bit seq [5];

    reset_n = 1'b0; ctl_hold = 1'b1; ctl_svc_lo = 1; ctl_svc_hi = 5;
    a_req = 0; a_we = 0; a_addr = '0; a_din = '0; a_wtbt = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_din = '0; b_wtbt = '0;
    ctl_mem[27'h100] = 16'hBEEF; ref_mem[27'h100] = 16'hBEEF;

    vecs[0] = '{1, 0, 27'h100, 16'h0, 2'd0, 0, 0, 27'h0, 16'h0, 2'd0, 0, 1, 16'hBEEF};
    vecs[1] = '{0, 0, 27'h0, 16'h0, 2'd0, 1, 1, 27'h203, 16'h00A5, 2'd0, 1, 1, 16'h0000};
    vecs[2] = '{0, 0, 27'h0, 16'h0, 2'd0, 1, 0, 27'h203, 16'h0, 2'd0, 1, 1, 16'h00A5};
    vecs[3] = '{1, 1, 27'h10, 16'h1234, 2'd1, 1, 0, 27'h100, 16'h0, 2'd0, 0, 1, 16'hBEEF};
    vecs[4] = '{0, 0, 27'h0, 16'h0, 2'd0, 0, 0, 27'h0, 16'h0, 2'd0, 1, 1, 16'hBEEF};
    vecs[5] = '{1, 0, 27'h10, 16'h0, 2'd0, 0, 0, 27'h0, 16'h0, 2'd0, 0, 1, 16'h1234};
    vecs[6] = '{0, 0, 27'h0, 16'h0, 2'd0, 1, 0, 27'h55, 16'h0, 2'd2, 1, 1, dflt(27'h55)};
    vecs[7] = '{1, 0, 27'h7FFFFFF, 16'h0, 2'd3, 0, 0, 27'h0, 16'h0, 2'd0, 0, 1, dflt(27'h7FFFFFF)};
    vecs[8] = '{0, 0, 27'h0, 16'h0, 2'd0, 1, 1, 27'h7FFFFFF, 16'hFFFF, 2'd3, 1, 1, dflt(27'h55)};

    repeat (3) @(posedge clk);
    @(negedge clk); #2; reset_n = 1'b1;

    // Controller still starting up: request must wait for ready.
    @(posedge clk); #1;
    set_a(1'b0, 27'h100, 16'h0, 2'd0);
    n_gnt = 0; n_strb = 0;
    repeat (200) begin
      @(posedge clk); #1;
      if (a_gnt || b_gnt) n_gnt++;
      if (sd_rd || sd_we) n_strb++;
    end
    chk("startup_no_gnt", 32'(n_gnt), 32'd0);
    chk("startup_no_strobe", 32'(n_strb), 32'd0);
    @(negedge clk); ctl_hold = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (a_gnt) begin lat = i; break; end
    end
    chk("startup_gnt_latency", 32'(lat), 32'd2);
    a_req = 1'b0;
    wait_done(1'b0, ok);
    chk("startup_done", 32'(ok), 32'd1);
    chk("startup_dout", 32'(a_dout), 32'hBEEF);

    foreach (vecs[i]) run_row(i, vecs[i]);

    // Both ports requesting continuously.
    @(posedge clk); #1;
    set_a(1'b0, 27'($urandom_range(0, 15)), 16'h0, 2'd0);
    set_b(1'b0, 27'($urandom_range(0, 15)), 16'h0, 2'd0);
    for (int k = 0; k < 5; k++) begin
      wait_gnt(gb, ok);
      chk("cont_gnt_seen", 32'(ok), 32'd1);
      seq[k] = gb;
      if (k >= 3) begin
        if (gb) b_req = 1'b0; else a_req = 1'b0;
      end else if (gb) set_b(1'b0, 27'($urandom_range(0, 15)), 16'h0, 2'd0);
      else set_a(1'b0, 27'($urandom_range(0, 15)), 16'h0, 2'd0);
    end
    for (int k = 0; k < 4; k++)
      chk($sformatf("cont_order%0d", k), 32'(seq[k]), 32'(RR ? k[0] : 1'b0));
    wait_idle("cont_idle");

    // Back-to-back reads on port A.
    e0 = ctl_edges;
    @(posedge clk); #1;
    set_a(1'b0, 27'h100, 16'h0, 2'd0);
    wait_gnt(gb, ok);
    chk("b2b_gnt1", 32'({ok, gb}), 32'd2);
    a_req = 1'b0;
    @(posedge clk); #1;
    set_a(1'b0, 27'h10, 16'h0, 2'd0);
    wait_gnt(gb, ok);
    chk("b2b_gnt2", 32'({ok, gb}), 32'd2);
    a_req = 1'b0;
    wait_done(1'b0, ok);
    chk("b2b_dout", 32'({ok, a_dout}), 32'h11234);
    wait_idle("b2b_idle");
    chk("b2b_edges", 32'(ctl_edges - e0), 32'd2);

    // Reset while waiting for ready to return.
    ctl_svc_lo = 10; ctl_svc_hi = 10;
    @(posedge clk); #1;
    set_a(1'b0, 27'h10, 16'h0, 2'd0);
    wait_gnt(gb, ok);
    a_req = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (!sd_ready) begin ok = 1'b1; break; end
    end
    chk("rst_wh_ready_low", 32'(ok), 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    reset_n = 1'b0; ctl_hold = 1'b1;
    #1;
    chk("rst_wh_async", 32'({sd_rd, busy, a_done}), 32'd0);
    repeat (3) @(negedge clk);
    #2; reset_n = 1'b1;
    @(negedge clk); ctl_hold = 1'b0;
    ctl_svc_lo = 1; ctl_svc_hi = 5;
    run_row(100, vecs[0]);
    wait_idle("rst_wh_idle");

    // Randomized traffic against the scoreboard.
    e0 = gnt_total;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(posedge clk); #1;
      if (a_gnt) a_req = 1'b0;
      if (b_gnt) b_req = 1'b0;
      if (cyc < 1200) begin
        if (!a_req && !a_gnt && $urandom_range(0, 3) == 0)
          set_a(1'($urandom_range(0, 1)), 27'($urandom_range(0, 15)), 16'($urandom), 2'($urandom_range(0, 3)));
        if (!b_req && !b_gnt && $urandom_range(0, 3) == 0)
          set_b(1'($urandom_range(0, 1)), 27'($urandom_range(0, 15)), 16'($urandom), 2'($urandom_range(0, 3)));
      end
    end
    wait_idle("rand_idle");
    chk("rand_progress", 32'(gnt_total - e0 >= 50), 32'd1);
    chk("edges_eq_grants", 32'(ctl_edges), 32'(gnt_total));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdram_arb.md
# sdram_arb

Two-client request arbiter and handshake bridge placed directly upstream of the SDRAM controller (`sdram`). It accepts word/byte read and write requests from two clients (port A, port B) over a req/gnt/done handshake and converts each granted request into the controller's edge-triggered `rd`/`we` strobes and `ready` completion protocol. It serialises transactions, keeps each strobe low long enough to re-arm the controller's edge detector, and returns read data to the requesting client.

## Interface
Parameters:
- `ADDR_W`, 27, byte address width; matches controller `addr`.
- `DATA_W`, 16, data width; matches controller `din`/`dout`.

Ports:
- `clk`  in  1  system clock, same clock as the controller.
- `reset_n`  in  1  asynchronous, active-low reset.
- `a_req`, `b_req`  in  1  request valid; held with fields stable until matching `*_gnt`.
- `a_we`, `b_we`  in  1  1 = write, 0 = read.
- `a_addr`, `b_addr`  in  ADDR_W  byte address.
- `a_wtbt`, `b_wtbt`  in  2  byte-write select, passed through to the controller unchanged.
- `a_din`, `b_din`  in  DATA_W  write data.
- `a_gnt`, `b_gnt`  out  1  one-cycle pulse: request latched.
- `a_done`, `b_done`  out  1  one-cycle pulse: transaction complete.
- `a_dout`, `b_dout`  out  DATA_W  read data; valid with `*_done`, held until the next read completes on that port.
- `sd_addr`  out  ADDR_W, `sd_din`  out  DATA_W, `sd_wtbt`  out  2  controller request fields.
- `sd_rd`, `sd_we`  out  1  controller strobes; the controller acts on the rising edge.
- `sd_dout`  in  DATA_W, `sd_ready`  in  1  controller read data and ready.
- `busy`  out  1  high in every state other than IDLE.

## Operation
- States: IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, GAP.
- IDLE: when `sd_ready`=1 and at least one `*_req` is set, select a port, latch its addr/din/wtbt/we into the `sd_*` field registers, record the port index, then go to ISSUE. While `sd_ready`=0 (controller startup), nothing is accepted.
- ISSUE: drive `sd_rd` or `sd_we` (registered) high for the latched direction, pulse the selected `*_gnt`, then go to WAIT_LOW.
- WAIT_LOW: remain here until `sd_ready`=0, then go to WAIT_HIGH. The strobe stays high.
- WAIT_HIGH: on `sd_ready`=1, capture `sd_dout` into the selected `*_dout` (reads only; writes leave `*_dout` untouched), drop the strobe, pulse the selected `*_done` on the next cycle, then go to GAP.
- GAP: one cycle with both strobes low, then go to IDLE. This guarantees the controller sees a low level before the next rising edge.
- Only one strobe is ever high at a time, and only one transaction is ever outstanding.
- A read that hits the controller's open-word shortcut still produces a ready fall/rise; no special case is needed.
- `*_req` is ignored outside IDLE. A client may re-assert `*_req` from the cycle after its `*_gnt`.
- Reset (async assert) forces state IDLE and all outputs to 0, including `*_dout`, `sd_*` and `busy`, and sets the round-robin pointer to "last=B". An in-flight controller operation is abandoned without a `*_done` pulse.

## Timing
- Accept in IDLE at cycle T0.
- `*_gnt` and the strobe are high at T1.
- The controller drops `ready`, visible at T2.
- Minimum accept-to-`*_done` latency is T0 + controller service time + 2 cycles.
- The strobe falls in the cycle after `sd_ready` is observed high.
- Minimum spacing between consecutive accepts is 5 cycles plus controller service time.
- All outputs are registered; there is no combinational path from `*_req` or `sd_ready` to any output.

## Configuration
- `SDRAM_ARB_RR_EN` defined: round-robin arbitration. When both ports request in the same IDLE cycle, the port not granted last wins. The pointer updates on each grant.
- `SDRAM_ARB_RR_EN` undefined: fixed priority, port A always wins ties. The pointer logic is removed.

## Structure
- Package `sdram_arb_pkg` holds:
  - `state_t` enum (IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, GAP);
  - `port_t` typedef (PORT_A, PORT_B);
  - default `ADDR_W`/`DATA_W` constants.
- Sub-module `sdram_arb_sel` is the combinational winner selector. Inputs: both `*_req` and the last-grant pointer. Output: winner index plus a valid flag. It contains the `SDRAM_ARB_RR_EN` conditional.

## Test plan
- Port A read, addr 0x0000100, controller model returns 0xBEEF. Required: `sd_rd` rises once, `a_gnt` pulses at T1, `a_dout`=0xBEEF with `a_done`, `b_*` outputs stay 0.
- Port B write, addr 0x0000203, din 0x00A5, wtbt 2'b00. Required: `sd_we` rises with `sd_addr`=0x0000203, `sd_din`=0x00A5, `sd_wtbt`=0; `b_done` pulses; `b_dout` unchanged.
- Both ports request continuously, 4 transactions. With `SDRAM_ARB_RR_EN`: grants A,B,A,B. Without: A,A,A,A.
- `sd_ready` held 0 for 200 cycles after reset with `a_req`=1. Required: no `a_gnt` and both strobes low; the grant occurs 1 cycle after `sd_ready` rises.
- Back-to-back port A reads. Required: strobe low for ≥1 cycle between transactions and exactly one controller rising edge per `a_gnt`.
- `reset_n` asserted during WAIT_HIGH. Required: `sd_rd`, `busy` and `a_done` are 0 immediately; after release the first accept is clean.
